uart_tx: RTL and testbench

- Serial UART transmitter; the upstream stage that drives the rx line of the existing uart receiver.
- Accepts parallel bytes over a valid/ready handshake and serialises each as a frame: start bit, data LSB-first, optional parity, stop bit(s).
- Bit timing comes from a clock-cycle counter, so the receiver bench and system can run on the same clk.

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter with a valid/ready byte interface.
// Frame layout: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// Bit timing is a clk-cycle counter, so the serial line shares clk with the receiver.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 20,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  // Reject illegal parameterisations at elaboration time.
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1'b1) begin : g_bad_param
    $error("uart_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // End of the current serial bit period.
  always_comb begin
    bit_end = (baud_cnt == BAUD_LAST);
  end

  // Handshake status decoded from the registered state only.
  always_comb begin
    tx_ready = (state == S_IDLE);
    busy     = (state != S_IDLE);
  end

  // Frame sequencer; tx and done are registered so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          if (tx_valid) begin
            shreg      <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^tx_data) ^ PARITY_ODD;
`endif
            tx         <= 1'b0;
            state      <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // tx is loaded one bit ahead from shreg[1] because the shift lands on the same edge.
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= parity_bit;
              state   <= S_PARITY;
`else
              tx      <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        // bit_cnt is reused to count stop bits.
        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with default parameters.
// Covers UART_TX_PARITY_EN builds too (frame length and parity bit follow the macro).
module tb_uart_tx;

  localparam int CPB = 20;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int NBITS = 1 + DB + PB + 1;
  localparam int FRAME = NBITS * CPB;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (1),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  // Expected line level for frame bit position idx (even parity when enabled).
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return d[idx-1];
    if (PB == 1 && idx == DB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered #1 after the acceptance edge; returns #1 after the edge that ends the frame.
  task automatic run_frame(input logic [7:0] d, input string tag, input bit abuse);
    logic [7:0] rec;
    int         bidx;
    rec = 8'h00;
    for (int cyc = 0; cyc < FRAME; cyc++) begin
      bidx = cyc / CPB;
      check({tag, " tx"}, 32'(tx), 32'(frame_bit(d, bidx)));
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " ready"}, 32'(tx_ready), 32'd0);
      if ((cyc % CPB) == CPB / 2 && bidx >= 1 && bidx <= DB) rec[bidx-1] = tx;
      if (abuse) begin
        tx_valid = ~tx_valid;
        tx_data  = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    check({tag, " end done"}, 32'(done), 32'd1);
    check({tag, " end ready"}, 32'(tx_ready), 32'd1);
    check({tag, " end busy"}, 32'(busy), 32'd0);
    check({tag, " end tx"}, 32'(tx), 32'd1);
    check({tag, " loopback"}, 32'(rec), 32'(d));
  endtask

  initial begin
    // Asynchronous reset with tx_valid already high.
    #1 rst = 1'b0;
    #1;
    check("rst tx", 32'(tx), 32'd1);
    check("rst ready", 32'(tx_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check("rst hold ready", 32'(tx_ready), 32'd1);
    check("rst hold tx", 32'(tx), 32'd1);
    @(negedge clk) rst = 1'b1;

    // First edge after release accepts 0x55.
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    run_frame(8'h55, "f55", 1'b0);
    @(posedge clk); #1;
    check("f55 done pulse", 32'(done), 32'd0);
    check("f55 idle ready", 32'(tx_ready), 32'd1);
    check("f55 idle tx", 32'(tx), 32'd1);

    // Back-to-back with tx_valid held: second acceptance one cycle after done.
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data  = 8'h0F;
    run_frame(8'hA3, "b2b_a3", 1'b0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    run_frame(8'h0F, "b2b_0f", 1'b0);
    @(posedge clk); #1;
    check("b2b idle ready", 32'(tx_ready), 32'd1);

    // Handshake abuse during a frame.
    tx_data  = 8'hC6;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    run_frame(8'hC6, "abuse", 1'b1);
    tx_valid = 1'b0;
    @(posedge clk); #1;
    check("abuse no extra accept", 32'(tx_ready), 32'd1);
    check("abuse idle tx", 32'(tx), 32'd1);

    // Mid-frame reset during data bit 3 of 0x00.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (85) @(posedge clk);
    #1;
    check("midrst pre tx", 32'(tx), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst tx", 32'(tx), 32'd1);
    check("midrst ready", 32'(tx_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("midrst hold tx", 32'(tx), 32'd1);
    @(negedge clk) rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("midrst no resume tx", 32'(tx), 32'd1);
    check("midrst no resume ready", 32'(tx_ready), 32'd1);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    run_frame(8'h5A, "post_rst", 1'b0);
    @(posedge clk); #1;

    // Odd population byte exercises the parity bit when enabled.
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    run_frame(8'h07, "b07", 1'b0);
    @(posedge clk); #1;
    check("b07 done pulse", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
